// File: rtl/mult_arbiter.sv
// Two-port round-robin arbiter/sequencer in front of a shared shift-add multiplier.
// Buffers one request per port, drives the start pulse, returns products with a one-cycle Ack.
module mult_arbiter #(
    parameter int WIDTH        = 16,
    parameter int START_CYCLES = 2,
    parameter int TIMEOUT      = 64
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic                 Req0,
    input  logic [WIDTH-1:0]     A0,
    input  logic [WIDTH-1:0]     B0,
    output logic                 Busy0,
    output logic                 Ack0,
    output logic [2*WIDTH-1:0]   Prod0,
    output logic                 Err0,
    input  logic                 Req1,
    input  logic [WIDTH-1:0]     A1,
    input  logic [WIDTH-1:0]     B1,
    output logic                 Busy1,
    output logic                 Ack1,
    output logic [2*WIDTH-1:0]   Prod1,
    output logic                 Err1,
    output logic                 Mul_St,
    output logic [WIDTH-1:0]     Mul_A,
    output logic [WIDTH-1:0]     Mul_B,
    input  logic                 Mul_Idle,
    input  logic                 Mul_Done,
    input  logic [2*WIDTH-1:0]   Mul_Produto,
    output logic                 Owner,
    output logic                 Active
);
    localparam int CMAX = (TIMEOUT > START_CYCLES) ? TIMEOUT : START_CYCLES;
    localparam int CW   = (CMAX > 1) ? $clog2(CMAX) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               owner_q, owner_d;
    logic               last_q, last_d;
    logic               pend0_q, pend0_d, pend1_q, pend1_d;
    logic [WIDTH-1:0]   a0_q, a0_d, b0_q, b0_d, a1_q, a1_d, b1_q, b1_d;
    logic [WIDTH-1:0]   mula_q, mula_d, mulb_q, mulb_d;
    logic [2*WIDTH-1:0] prod0_q, prod0_d, prod1_q, prod1_d;
    logic               err0_q, err0_d, err1_q, err1_d;
    logic               grant, rel0, rel1;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            pend0_q <= 1'b0;
            pend1_q <= 1'b0;
            a0_q    <= '0;
            b0_q    <= '0;
            a1_q    <= '0;
            b1_q    <= '0;
            mula_q  <= '0;
            mulb_q  <= '0;
            prod0_q <= '0;
            prod1_q <= '0;
            err0_q  <= 1'b0;
            err1_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            a0_q    <= a0_d;
            b0_q    <= b0_d;
            a1_q    <= a1_d;
            b1_q    <= b1_d;
            mula_q  <= mula_d;
            mulb_q  <= mulb_d;
            prod0_q <= prod0_d;
            prod1_q <= prod1_d;
            err0_q  <= err0_d;
            err1_q  <= err1_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        owner_d = owner_q;
        last_d  = last_q;
        pend0_d = pend0_q;
        pend1_d = pend1_q;
        a0_d    = a0_q;
        b0_d    = b0_q;
        a1_d    = a1_q;
        b1_d    = b1_q;
        mula_d  = mula_q;
        mulb_d  = mulb_q;
        prod0_d = prod0_q;
        prod1_d = prod1_q;
        err0_d  = err0_q;
        err1_d  = err1_q;

        // With both pending the port that was not served last wins.
        grant = (pend0_q && pend1_q) ? ~last_q : pend1_q;
        rel0  = (state_q == S_RESP) && !owner_q;
        rel1  = (state_q == S_RESP) && owner_q;

        case (state_q)
            S_IDLE: begin
                if ((pend0_q || pend1_q) && Mul_Idle) begin
                    state_d = S_ISSUE;
                    owner_d = grant;
                    cnt_d   = '0;
                    mula_d  = grant ? a1_q : a0_q;
                    mulb_d  = grant ? b1_q : b0_q;
                end
            end
            S_ISSUE: begin
                if (cnt_q == CW'(START_CYCLES - 1)) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_q + 1'b1;
                if (Mul_Done) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        prod1_d = Mul_Produto;
                        err1_d  = 1'b0;
                    end else begin
                        prod0_d = Mul_Produto;
                        err0_d  = 1'b0;
                    end
                end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                    state_d = S_RESP;
                    if (owner_q) begin
                        prod1_d = '0;
                        err1_d  = 1'b1;
                    end else begin
                        prod0_d = '0;
                        err0_d  = 1'b1;
                    end
                end
            end
            S_RESP: begin
                last_d  = owner_q;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // The owner's slot frees at the end of RESP, so a Req in that cycle refills it.
        if (Req0 && (!pend0_q || rel0)) begin
            pend0_d = 1'b1;
            a0_d    = A0;
            b0_d    = B0;
        end else if (rel0) begin
            pend0_d = 1'b0;
        end
        if (Req1 && (!pend1_q || rel1)) begin
            pend1_d = 1'b1;
            a1_d    = A1;
            b1_d    = B1;
        end else if (rel1) begin
            pend1_d = 1'b0;
        end
    end

    assign Busy0  = pend0_q;
    assign Busy1  = pend1_q;
    assign Ack0   = rel0;
    assign Ack1   = rel1;
    assign Prod0  = prod0_q;
    assign Prod1  = prod1_q;
    assign Err0   = err0_q;
    assign Err1   = err1_q;
    assign Mul_St = (state_q == S_ISSUE);
    assign Mul_A  = mula_q;
    assign Mul_B  = mulb_q;
    assign Owner  = owner_q;
    assign Active = (state_q != S_IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Bench for mult_arbiter: behavioural multiplier responder, transaction-timeline reference model,
// per-cycle compare process, directed scenarios with literal expectations, then random traffic.
module tb_mult_arbiter;
    localparam int W  = 16;
    localparam int S  = 2;
    localparam int TO = 64;

    logic           Clk = 1'b0;
    logic           Reset = 1'b1;
    logic           Req0 = 1'b0, Req1 = 1'b0;
    logic [W-1:0]   A0 = '0, B0 = '0, A1 = '0, B1 = '0;
    logic           Busy0, Ack0, Err0, Busy1, Ack1, Err1;
    logic [2*W-1:0] Prod0, Prod1;
    logic           Mul_St, Owner, Active;
    logic [W-1:0]   Mul_A, Mul_B;
    logic           Mul_Idle = 1'b1, Mul_Done = 1'b0;
    logic [2*W-1:0] Mul_Produto = '0;

    always #5 Clk = ~Clk;

    mult_arbiter #(.WIDTH(W), .START_CYCLES(S), .TIMEOUT(TO)) dut (
        .Clk(Clk), .Reset(Reset),
        .Req0(Req0), .A0(A0), .B0(B0), .Busy0(Busy0), .Ack0(Ack0), .Prod0(Prod0), .Err0(Err0),
        .Req1(Req1), .A1(A1), .B1(B1), .Busy1(Busy1), .Ack1(Ack1), .Prod1(Prod1), .Err1(Err1),
        .Mul_St(Mul_St), .Mul_A(Mul_A), .Mul_B(Mul_B), .Mul_Idle(Mul_Idle),
        .Mul_Done(Mul_Done), .Mul_Produto(Mul_Produto), .Owner(Owner), .Active(Active)
    );

    int vectors = 0;
    int miscompares = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- multiplier responder (acts on negedges) ----------------
    bit           hang = 1'b0, mul_clr = 1'b0, spur_en = 1'b0;
    bit           mbusy = 1'b0;
    int           mcnt = 0;
    int           lat_lo = 2, lat_hi = 12;
    logic [W-1:0] ma, mb;

    initial forever begin
        @(negedge Clk);
        if (mul_clr) begin
            mbusy = 1'b0; Mul_Idle = 1'b1; Mul_Done = 1'b0;
        end else if (Mul_Done) begin
            Mul_Done = 1'b0; Mul_Idle = 1'b1; mbusy = 1'b0;
        end else if (mbusy) begin
            if (!hang) begin
                mcnt--;
                if (mcnt == 0) begin
                    Mul_Done = 1'b1;
                    Mul_Produto = 32'(ma) * 32'(mb);
                end
            end
        end else if (Mul_St) begin
            ma = Mul_A; mb = Mul_B; mbusy = 1'b1; Mul_Idle = 1'b0;
            mcnt = int'($urandom_range(lat_hi, lat_lo));
        end else if (spur_en && $urandom_range(7, 0) == 0) begin
            Mul_Done = 1'b1;
            Mul_Produto = $urandom;
        end
    end

    // ---------------- reference model: timeline of the current service ----------------
    int           cyc = 0;
    bit           m_pend[2], m_err[2];
    logic [W-1:0] m_a[2], m_b[2];
    logic [31:0]  m_prod[2];
    bit           m_last = 1'b1, m_active = 1'b0, m_owner = 1'b0;
    int           m_ws = 0, m_resp = -1;
    logic [W-1:0] m_mula = '0, m_mulb = '0, m_sa = '0, m_sb = '0;

    task automatic model_step();
        int  c;
        bit  fin;
        bit  g;
        bit  rq[2];
        logic [W-1:0] ra[2], rb[2];
        c = cyc;
        fin = 1'b0;
        rq[0] = Req0; rq[1] = Req1;
        ra[0] = A0; ra[1] = A1; rb[0] = B0; rb[1] = B1;
        if (Reset) begin
            for (int p = 0; p < 2; p++) begin
                m_pend[p] = 1'b0; m_err[p] = 1'b0; m_prod[p] = '0; m_a[p] = '0; m_b[p] = '0;
            end
            m_last = 1'b1; m_active = 1'b0; m_owner = 1'b0; m_resp = -1;
            m_mula = '0; m_mulb = '0;
        end else begin
            if (m_active && c >= m_ws && m_resp == -1) begin
                if (Mul_Done) begin
                    m_resp = c + 1; m_prod[m_owner] = Mul_Produto; m_err[m_owner] = 1'b0;
                end else if (c - m_ws == TO - 1) begin
                    m_resp = c + 1; m_prod[m_owner] = '0; m_err[m_owner] = 1'b1;
                end
            end else if (m_active && c == m_resp) begin
                fin = 1'b1; m_active = 1'b0; m_last = m_owner;
            end else if (!m_active && (m_pend[0] || m_pend[1]) && Mul_Idle) begin
                if (m_pend[0] && m_pend[1]) g = !m_last;
                else g = m_pend[1];
                m_active = 1'b1; m_owner = g; m_ws = c + 1 + S; m_resp = -1;
                m_mula = m_a[g]; m_mulb = m_b[g]; m_sa = m_a[g]; m_sb = m_b[g];
            end
            for (int p = 0; p < 2; p++) begin
                if (rq[p] && (!m_pend[p] || (fin && m_owner == p))) begin
                    m_pend[p] = 1'b1; m_a[p] = ra[p]; m_b[p] = rb[p];
                end else if (fin && m_owner == p) begin
                    m_pend[p] = 1'b0;
                end
            end
        end
        cyc = cyc + 1;
    endtask

    initial forever begin
        @(posedge Clk);
        model_step();
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        bit eack[2];
        @(negedge Clk);
        if (chk_en) begin
            eack[0] = m_active && cyc == m_resp && m_owner == 1'b0;
            eack[1] = m_active && cyc == m_resp && m_owner == 1'b1;
            chk("Busy0", Busy0, m_pend[0]);
            chk("Busy1", Busy1, m_pend[1]);
            chk("Active", Active, m_active);
            if (m_active) chk("Owner", Owner, m_owner);
            chk("Mul_St", Mul_St, m_active && cyc < m_ws);
            chk("Ack0", Ack0, eack[0]);
            chk("Ack1", Ack1, eack[1]);
            chk("Prod0", Prod0, m_prod[0]);
            chk("Prod1", Prod1, m_prod[1]);
            chk("Err0", Err0, m_err[0]);
            chk("Err1", Err1, m_err[1]);
            chk("Mul_A", Mul_A, m_mula);
            chk("Mul_B", Mul_B, m_mulb);
            chk("ack_overlap", Ack0 & Ack1, 1'b0);
            if (eack[0] && !m_err[0]) chk("prod0_arith", Prod0, 32'(m_sa) * 32'(m_sb));
            if (eack[1] && !m_err[1]) chk("prod1_arith", Prod1, 32'(m_sa) * 32'(m_sb));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic tick();
        @(posedge Clk); #1;
    endtask

    task automatic req(input int p, input logic [W-1:0] a, input logic [W-1:0] b);
        if (p == 0) begin Req0 = 1'b1; A0 = a; B0 = b; end
        else begin Req1 = 1'b1; A1 = a; B1 = b; end
    endtask

    task automatic rel();
        Req0 = 1'b0; Req1 = 1'b0;
    endtask

    task automatic pulse_reset();
        Reset = 1'b1; tick(); Reset = 1'b0;
    endtask

    task automatic wait_any(input int maxc, output int port);
        port = -1;
        for (int i = 0; i < maxc; i++) begin
            @(negedge Clk);
            if (Ack0) begin port = 0; break; end
            if (Ack1) begin port = 1; break; end
        end
        if (port < 0) begin
            vectors++; miscompares++;
            $display("FAIL ack_timeout: no Ack within %0d cycles, required one", maxc);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    int port, extra, wcnt;
    int exp_p[8] = '{12, 20, 225, 0, 15, 182, 0, 49};
    logic [W-1:0] pa[6] = '{16'd15, 16'd0, 16'd1, 16'd14, 16'd8, 16'd7};
    logic [W-1:0] pb[6] = '{16'd15, 16'd9, 16'd15, 16'd13, 16'd0, 16'd7};

    initial begin
        repeat (3) tick();
        Reset = 1'b0;
        chk_en = 1'b1;
        @(negedge Clk);
        chk("rst_Active", Active, 1'b0);
        chk("rst_Busy0", Busy0, 1'b0);
        chk("rst_Owner", Owner, 1'b0);
        chk("rst_Prod0", Prod0, 32'd0);
        chk("rst_Mul_St", Mul_St, 1'b0);

        // single request 3x5
        req(0, 16'd3, 16'd5); tick(); rel();
        wait_any(100, port);
        chk("t1_port", port, 0);
        chk("t1_Prod0", Prod0, 32'd15);
        chk("t1_Err0", Err0, 1'b0);
        @(negedge Clk);
        chk("t1_Busy0_after", Busy0, 1'b0);
        repeat (5) @(negedge Clk);
        chk("t1_Prod0_held", Prod0, 32'd15);

        // simultaneous requests after reset: port 0 first
        tick(); pulse_reset();
        req(0, 16'd7, 16'd9); req(1, 16'd12, 16'd11); tick(); rel();
        wait_any(100, port);
        chk("t2_first", port, 0);
        chk("t2_Prod0", Prod0, 32'd63);
        wait_any(100, port);
        chk("t2_second", port, 1);
        chk("t2_Prod1", Prod1, 32'd132);

        // continuous re-requests: strict alternation
        tick(); pulse_reset();
        req(0, 16'd3, 16'd4); req(1, 16'd2, 16'd10); tick(); rel();
        for (int k = 0; k < 8; k++) begin
            wait_any(100, port);
            chk("t3_order", port, k % 2);
            chk("t3_prod", (port == 1) ? Prod1 : Prod0, 32'(exp_p[k]));
            if (k < 6) begin
                req(port, pa[k], pb[k]); tick(); rel();
            end
        end

        // second Req0 while busy is ignored
        tick();
        req(0, 16'd2, 16'd3); tick(); rel(); tick(); tick();
        req(0, 16'd9, 16'd9); tick(); rel();
        wait_any(100, port);
        chk("t4_port", port, 0);
        chk("t4_Prod0", Prod0, 32'd6);
        extra = 0;
        repeat (20) begin
            @(negedge Clk);
            if (Ack0) extra++;
        end
        chk("t4_single_ack", extra, 0);
        chk("t4_Busy0", Busy0, 1'b0);

        // hung multiplier -> timeout
        tick();
        hang = 1'b1;
        req(0, 16'd4, 16'd4); tick(); rel();
        wcnt = 0; port = -1;
        for (int i = 0; i < 200; i++) begin
            @(negedge Clk);
            if (Ack0) begin port = 0; break; end
            if (Active && !Mul_St) wcnt++;
        end
        chk("t5_ack", port, 0);
        chk("t5_wait_cycles", wcnt, TO);
        chk("t5_Err0", Err0, 1'b1);
        chk("t5_Prod0", Prod0, 32'd0);
        tick(); mul_clr = 1'b1; tick(); mul_clr = 1'b0; hang = 1'b0;
        req(0, 16'd5, 16'd6); tick(); rel();
        wait_any(100, port);
        chk("t5_recover_Err0", Err0, 1'b0);
        chk("t5_recover_Prod0", Prod0, 32'd30);

        // reset mid-WAIT with both pending
        tick();
        lat_lo = 30; lat_hi = 30;
        req(0, 16'd11, 16'd2); req(1, 16'd6, 16'd6); tick(); rel();
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (Active && !Mul_St) break;
        end
        repeat (3) @(negedge Clk);
        Reset = 1'b1;
        @(posedge Clk); #1 Reset = 1'b0;
        @(negedge Clk);
        chk("t6_Active", Active, 1'b0);
        chk("t6_Busy0", Busy0, 1'b0);
        chk("t6_Busy1", Busy1, 1'b0);
        chk("t6_Ack0", Ack0, 1'b0);
        chk("t6_Ack1", Ack1, 1'b0);
        chk("t6_Prod0", Prod0, 32'd0);
        chk("t6_Mul_A", Mul_A, 16'd0);
        extra = 0;
        repeat (40) begin
            @(negedge Clk);
            if (Ack0 || Ack1) extra++;
        end
        chk("t6_no_ack", extra, 0);
        lat_lo = 2; lat_hi = 12;

        // random traffic with stray Done pulses outside service
        tick();
        spur_en = 1'b1;
        repeat (3000) begin
            Req0 = ($urandom_range(3, 0) == 0); A0 = W'($urandom); B0 = W'($urandom);
            Req1 = ($urandom_range(3, 0) == 0); A1 = W'($urandom); B1 = W'($urandom);
            tick();
        end
        rel();
        spur_en = 1'b0;
        repeat (100) tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
Two-port round-robin arbiter and sequencer in front of the shared 16x16 shift-add `Multiplicador` unit.
- Buffers one request per port and issues the start pulse (St) to the multiplier.
- Waits for the multiplier's Done, captures the product and returns it to the owning port with a one-cycle Ack.
- Provides a timeout guard so a hung multiplier cannot lock up the requesters.

Parameters:
WIDTH, 16, operand width; product is 2*WIDTH.
START_CYCLES, 2, number of cycles Mul_St is held high per issue.
TIMEOUT, 64, max cycles in WAIT before aborting with an error.

Ports:
Clk  in  1  system clock, rising edge.
Reset  in  1  synchronous, active-high reset.
Req0  in  1  port 0 request pulse; A0/B0 sampled in the same cycle.
A0  in  WIDTH  port 0 multiplicand.
B0  in  WIDTH  port 0 multiplier.
Busy0  out  1  port 0 request pending or in service.
Ack0  out  1  one-cycle pulse: Prod0/Err0 valid.
Prod0  out  2*WIDTH  port 0 last product, held until next Ack0.
Err0  out  1  timeout flag, valid with Ack0, held until next Ack0.
Req1, A1, B1, Busy1, Ack1, Prod1, Err1: identical for port 1.
Mul_St  out  1  start to multiplier.
Mul_A  out  WIDTH  to Multiplicando.
Mul_B  out  WIDTH  to Multiplicador.
Mul_Idle  in  1  multiplier idle.
Mul_Done  in  1  multiplier done.
Mul_Produto  in  2*WIDTH  multiplier product.
Owner  out  1  port currently granted; valid while Active=1.
Active  out  1  high in ISSUE, WAIT and RESP.

Behaviour:
- Reset (sync): every output is 0, FSM goes to IDLE, both pending bits are cleared, the count is cleared, and Last=1 (so port 0 wins first). Reset mid-operation aborts silently: no Ack is produced and buffered requests are lost.
- Request buffering:
  - Req_n=1 while pend_n=0 sets pend_n and latches A_n/B_n into the port buffer.
  - Req_n while pend_n=1 is ignored.
  - Busy_n = pend_n.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - Moves to ISSUE when (pend0 or pend1) and Mul_Idle=1.
  - Grant rule: if only one port is pending, grant it; if both are pending, grant the port != Last.
  - Owner is set to the granted port; Mul_A/Mul_B are loaded from that port's buffer.
- ISSUE:
  - Mul_St=1 for exactly START_CYCLES cycles; Mul_A/Mul_B stay stable.
  - Then go to WAIT with count=0.
- WAIT:
  - Mul_St=0; count increments every cycle.
  - Mul_Done=1: capture Mul_Produto into Prod_owner, clear Err_owner, go to RESP.
  - Otherwise, if count==TIMEOUT-1: set Prod_owner=0 and Err_owner=1, go to RESP.
  - If Done and timeout coincide, Done wins.
- RESP (one cycle):
  - Ack_owner=1.
  - pend_owner is cleared at the end of the cycle, unless Req_owner=1 in this cycle; then it is re-set with new operands.
  - Last<=Owner; go to IDLE.
- Mul_A/Mul_B hold their last value in IDLE. Ack is never asserted on both ports in the same cycle.
- Latency, single request, idle system:
  - Req at cycle 0 → pend at 1 → ISSUE at 2 → WAIT at 2+START_CYCLES → Ack one cycle after the Done cycle.
  - Minimum gap between back-to-back grants: one IDLE cycle.
- Fairness: with both ports continuously re-requesting, grants strictly alternate 0,1,0,1...
- Mul_Done outside WAIT is ignored. The product is not truncated: the full 2*WIDTH bits are passed.

Test Plan:
- Reset, then Req0 with A0=3, B0=5, using the real multiplier → Mul_St high for 2 cycles, then Ack0 pulse with Prod0=15, Err0=0, Busy0 falling after the Ack; Prod0 held at 15 afterwards.
- Req0 (A0=7,B0=9) and Req1 (A1=12,B1=11) in the same cycle → port 0 served first (Ack0, Prod0=63), then port 1 (Ack1, Prod1=132); Acks never overlap.
- Both ports re-request in each of their Ack cycles for 4 rounds, operands i×j for i,j in 0..15 → grant order 0,1,0,1...; every product equals A×B, including 15×15=225 and 0×N=0.
- Req0 pulsed again while Busy0=1 with different operands → ignored; Prod0 reflects the first operands only; a single Ack0.
- Mul_Done forced to 0 → after TIMEOUT=64 WAIT cycles, Ack0 with Err0=1, Prod0=0; next request with a working multiplier clears Err0.
- Reset asserted for one cycle mid-WAIT with both ports pending → all outputs 0 next cycle, no Ack, FSM in IDLE, Busy0=Busy1=0.
